// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - trap sequencer types, cause codes, CSR addresses and vector helper
package trap_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_VECTOR, ST_RET} state_e;
   typedef enum logic [1:0] {EV_NONE, EV_EXC, EV_MRET, EV_IRQ} event_e;

   localparam logic [3:0] EXC_FETCH_MISALIGN = 4'd0;
   localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
   localparam logic [3:0] EXC_EBREAK         = 4'd3;
   localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
   localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
   localparam logic [3:0] EXC_ECALL          = 4'd11;

   localparam logic [3:0] IRQ_MSI = 4'd3;
   localparam logic [3:0] IRQ_MTI = 4'd7;
   localparam logic [3:0] IRQ_MEI = 4'd11;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   // Only interrupts are offset in vectored mode; exceptions always land on the base.
   function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                               input logic        is_irq,
                                               input logic [3:0]  code);
      logic [31:0] base;
      base = mtvec & 32'hFFFF_FFFC;
      if (mtvec[1:0] == MTVEC_VECTORED && is_irq)
         base = base + {26'd0, code, 2'b00};
      return base;
   endfunction

endpackage

// File: rtl/trap_prio.sv
// rtl/trap_prio.sv - combinational arbiter picking the trap event at a retire boundary
module trap_prio import trap_pkg::*; (
   input  logic       exc_valid,
   input  logic [3:0] exc_code,
   input  logic       mret,
   input  logic [2:0] irq_pending,
   input  logic [2:0] mie,
   input  logic       mstatus_mie,
   output event_e     kind,
   output logic [3:0] code
);

   logic [2:0] irq_en;
   assign irq_en = irq_pending & mie & {3{mstatus_mie}};

   // Bit order is {MEI, MTI, MSI}, but MSI outranks MTI.
   always_comb begin
      kind = EV_NONE;
      code = 4'd0;
      if (exc_valid) begin
         kind = EV_EXC;
         code = exc_code;
      end else if (mret) begin
         kind = EV_MRET;
      end else if (irq_en[2]) begin
         kind = EV_IRQ;
         code = IRQ_MEI;
      end else if (irq_en[0]) begin
         kind = EV_IRQ;
         code = IRQ_MSI;
      end else if (irq_en[1]) begin
         kind = EV_IRQ;
         code = IRQ_MTI;
      end
   end

endmodule

// File: rtl/trap_seq.sv
// rtl/trap_seq.sv - machine-mode trap entry / mret sequencer owning mepc, mcause, mtval, mstatus
module trap_seq import trap_pkg::*; (
   input  logic        clk,
   input  logic        resetn,
   input  logic        retire,
   input  logic [31:0] pc,
   input  logic        exc_valid,
   input  logic [3:0]  exc_code,
   input  logic [31:0] exc_tval,
   input  logic        mret,
   input  logic [2:0]  irq_pending,
   input  logic [2:0]  mie,
   input  logic [31:0] mtvec,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic        stall,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] mepc,
   output logic [31:0] mcause,
   output logic [31:0] mtval,
   output logic        mstatus_mie,
   output logic        mstatus_mpie
);

   state_e      state_q;
   logic [31:0] cause_q, epc_q, tval_q;
   logic [31:0] mepc_q, mcause_q, mtval_q;
   logic        mie_q, mpie_q;
   logic        redirect_q;
   logic [31:0] redirect_pc_q;

   event_e      ev_kind;
   logic [3:0]  ev_code;
   logic [31:0] cause_d, epc_d, tval_d;
   logic        is_irq;

   trap_prio u_prio (
      .exc_valid   (exc_valid),
      .exc_code    (exc_code),
      .mret        (mret),
      .irq_pending (irq_pending),
      .mie         (mie),
      .mstatus_mie (mie_q),
      .kind        (ev_kind),
      .code        (ev_code)
   );

   // Interrupts resume after the interrupted instruction; pc+4 wraps naturally.
   assign is_irq  = (ev_kind == EV_IRQ);
   assign cause_d = {is_irq, 27'd0, ev_code};
   assign epc_d   = is_irq ? pc + 32'd4 : pc;
   assign tval_d  = is_irq ? 32'd0 : exc_tval;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         cause_q       <= 32'd0;
         epc_q         <= 32'd0;
         tval_q        <= 32'd0;
         mepc_q        <= 32'd0;
         mcause_q      <= 32'd0;
         mtval_q       <= 32'd0;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               redirect_q    <= 1'b0;
               redirect_pc_q <= 32'd0;
               if (retire && (ev_kind == EV_EXC || ev_kind == EV_IRQ)) begin
                  cause_q <= cause_d;
                  epc_q   <= epc_d;
                  tval_q  <= tval_d;
                  state_q <= ST_SAVE;
               end else if (retire && ev_kind == EV_MRET) begin
                  mie_q         <= mpie_q;
                  mpie_q        <= 1'b1;
                  redirect_q    <= 1'b1;
                  redirect_pc_q <= mepc_q;
                  state_q       <= ST_RET;
               end else if (csr_we) begin
                  case (csr_addr)
                     CSR_MSTATUS: begin
                        mie_q  <= csr_wdata[3];
                        mpie_q <= csr_wdata[7];
                     end
                     CSR_MEPC:   mepc_q   <= csr_wdata & 32'hFFFF_FFFC;
                     CSR_MCAUSE: mcause_q <= csr_wdata;
                     CSR_MTVAL:  mtval_q  <= csr_wdata;
                     default: ;
                  endcase
               end
            end
            ST_SAVE: begin
               mepc_q        <= epc_q & 32'hFFFF_FFFC;
               mcause_q      <= cause_q;
               mtval_q       <= tval_q;
               mpie_q        <= mie_q;
               mie_q         <= 1'b0;
               redirect_q    <= 1'b1;
               redirect_pc_q <= trap_target(mtvec, cause_q[31], cause_q[3:0]);
               state_q       <= ST_VECTOR;
            end
            default: begin
               redirect_q    <= 1'b0;
               redirect_pc_q <= 32'd0;
               state_q       <= ST_IDLE;
            end
         endcase
      end
   end

   assign stall        = (state_q != ST_IDLE);
   assign redirect     = redirect_q;
   assign redirect_pc  = redirect_pc_q;
   assign mepc         = mepc_q;
   assign mcause       = mcause_q;
   assign mtval        = mtval_q;
   assign mstatus_mie  = mie_q;
   assign mstatus_mpie = mpie_q;

endmodule

// File: tb/tb_trap_seq.sv
// tb/tb_trap_seq.sv - randomized self-checking bench for trap_seq against a CSR-level model
module tb_trap_seq;

   logic        clk = 1'b0;
   logic        resetn;
   logic        retire;
   logic [31:0] pc;
   logic        exc_valid;
   logic [3:0]  exc_code;
   logic [31:0] exc_tval;
   logic        mret;
   logic [2:0]  irq_pending;
   logic [2:0]  mie;
   logic [31:0] mtvec;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        stall, redirect;
   logic [31:0] redirect_pc, mepc, mcause, mtval;
   logic        mstatus_mie, mstatus_mpie;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_mepc, m_mcause, m_mtval;
   logic        m_mie, m_mpie;

   logic [3:0]  exc_tab [6] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd6, 4'd11};
   logic [11:0] csr_tab [5] = '{12'h300, 12'h341, 12'h342, 12'h343, 12'h305};

   trap_seq dut (
      .clk          (clk),
      .resetn       (resetn),
      .retire       (retire),
      .pc           (pc),
      .exc_valid    (exc_valid),
      .exc_code     (exc_code),
      .exc_tval     (exc_tval),
      .mret         (mret),
      .irq_pending  (irq_pending),
      .mie          (mie),
      .mtvec        (mtvec),
      .csr_we       (csr_we),
      .csr_addr     (csr_addr),
      .csr_wdata    (csr_wdata),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .mepc         (mepc),
      .mcause       (mcause),
      .mtval        (mtval),
      .mstatus_mie  (mstatus_mie),
      .mstatus_mpie (mstatus_mpie)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_csrs(input string tag);
      check_eq({tag, ".mepc"}, mepc, m_mepc);
      check_eq({tag, ".mcause"}, mcause, m_mcause);
      check_eq({tag, ".mtval"}, mtval, m_mtval);
      check_eq({tag, ".mie"}, {31'd0, mstatus_mie}, {31'd0, m_mie});
      check_eq({tag, ".mpie"}, {31'd0, mstatus_mpie}, {31'd0, m_mpie});
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, ".stall"}, {31'd0, stall}, 32'd0);
      check_eq({tag, ".redirect"}, {31'd0, redirect}, 32'd0);
   endtask

   task automatic model_reset();
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mie = 0; m_mpie = 0;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d, input string tag);
      csr_we = 1'b1; csr_addr = a; csr_wdata = d;
      @(negedge clk);
      csr_we = 1'b0;
      case (a)
         12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
         12'h341: m_mepc = {d[31:2], 2'b00};
         12'h342: m_mcause = d;
         12'h343: m_mtval = d;
         default: ;
      endcase
      check_csrs(tag);
      check_quiet(tag);
   endtask

   // One retiring instruction; the expected outcome is decided from the model's
   // architectural state before the edge, then the full trap/mret timeline is checked.
   task automatic do_retire(input logic [31:0] p, input logic ev, input logic [3:0] ec,
                            input logic [31:0] tv, input logic mr, input logic [2:0] irq,
                            input logic [2:0] en, input logic [31:0] vec, input logic junk,
                            input string tag);
      int          kind;
      logic [2:0]  act;
      logic [3:0]  code;
      logic [31:0] cause, epc, tval, tgt;
      act = irq & en & {3{m_mie}};
      kind = 0; cause = 0; epc = 0; tval = 0; code = 0;
      if (ev) begin
         kind = 1; cause = {28'd0, ec}; epc = p; tval = tv;
      end else if (mr) begin
         kind = 2;
      end else if (act != 3'b000) begin
         code = act[2] ? 4'd11 : (act[0] ? 4'd3 : 4'd7);
         kind = 1; cause = 32'h8000_0000 + {28'd0, code}; epc = p + 32'd4; tval = 0;
      end
      pc = p; exc_valid = ev; exc_code = ec; exc_tval = tv; mret = mr;
      irq_pending = irq; mie = en; mtvec = vec; retire = 1'b1;
      @(negedge clk);
      retire = 1'b0; exc_valid = 1'b0; mret = 1'b0;
      if (kind == 1) begin
         check_eq({tag, ".save_stall"}, {31'd0, stall}, 32'd1);
         check_eq({tag, ".save_redir"}, {31'd0, redirect}, 32'd0);
         if (junk) begin
            csr_we = 1'b1; csr_addr = csr_tab[$urandom_range(0, 3)]; csr_wdata = $urandom;
            retire = 1'b1; exc_valid = 1'b1; mret = $urandom_range(0, 1);
            irq_pending = 3'($urandom);
         end
         @(negedge clk);
         csr_we = 1'b0; retire = 1'b0; exc_valid = 1'b0; mret = 1'b0;
         m_mepc = {epc[31:2], 2'b00}; m_mcause = cause; m_mtval = tval;
         m_mpie = m_mie; m_mie = 1'b0;
         tgt = {vec[31:2], 2'b00};
         if (vec[1:0] == 2'b01 && cause[31]) tgt = tgt + 32'd4 * {28'd0, cause[3:0]};
         check_eq({tag, ".vec_stall"}, {31'd0, stall}, 32'd1);
         check_eq({tag, ".vec_redir"}, {31'd0, redirect}, 32'd1);
         check_eq({tag, ".vec_pc"}, redirect_pc, tgt);
         check_csrs({tag, ".trap"});
         @(negedge clk);
         check_quiet({tag, ".after_trap"});
      end else if (kind == 2) begin
         m_mie = m_mpie; m_mpie = 1'b1;
         check_eq({tag, ".ret_stall"}, {31'd0, stall}, 32'd1);
         check_eq({tag, ".ret_redir"}, {31'd0, redirect}, 32'd1);
         check_eq({tag, ".ret_pc"}, redirect_pc, m_mepc);
         check_csrs({tag, ".mret"});
         @(negedge clk);
         check_quiet({tag, ".after_mret"});
      end else begin
         check_quiet({tag, ".none"});
         check_csrs({tag, ".none"});
      end
   endtask

   initial begin
      resetn = 1'b0; retire = 0; pc = 0; exc_valid = 0; exc_code = 0; exc_tval = 0;
      mret = 0; irq_pending = 0; mie = 0; mtvec = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      check_quiet("reset");
      check_eq("reset.redirect_pc", redirect_pc, 32'd0);
      check_csrs("reset");
      resetn = 1'b1;
      @(negedge clk);

      csr_write(12'h300, 32'h8, "illegal.setup");
      do_retire(32'h100, 1, 4'd2, 32'h0000_FFFF, 0, 3'b000, 3'b000, 32'h200, 0, "illegal");

      csr_write(12'h300, 32'h8, "vtimer.setup");
      do_retire(32'h400, 0, 4'd0, 32'h0, 0, 3'b010, 3'b010, 32'h201, 0, "vtimer");

      csr_write(12'h300, 32'h8, "prio_exc.setup");
      do_retire(32'h500, 1, 4'd4, 32'h55, 0, 3'b100, 3'b100, 32'h201, 0, "prio_exc");
      csr_write(12'h300, 32'h8, "prio_irq.setup");
      do_retire(32'h600, 0, 4'd0, 32'h0, 0, 3'b110, 3'b110, 32'h200, 0, "prio_mei_mti");
      csr_write(12'h300, 32'h8, "prio_msi.setup");
      do_retire(32'h610, 0, 4'd0, 32'h0, 0, 3'b011, 3'b111, 32'h201, 0, "prio_msi_mti");

      csr_write(12'h341, 32'h104, "mret.mepc");
      csr_write(12'h300, 32'h80, "mret.mstatus");
      do_retire(32'h700, 0, 4'd0, 32'h0, 1, 3'b000, 3'b000, 32'h200, 0, "mret");

      csr_write(12'h300, 32'h80, "mret_irq.setup");
      do_retire(32'h800, 0, 4'd0, 32'h0, 1, 3'b100, 3'b100, 32'h200, 0, "mret_irq");
      do_retire(32'h900, 0, 4'd0, 32'h0, 0, 3'b100, 3'b100, 32'h200, 0, "irq_after_mret");

      csr_write(12'h300, 32'h0, "mask.setup");
      do_retire(32'hA00, 0, 4'd0, 32'h0, 0, 3'b100, 3'b100, 32'h200, 0, "masked");
      csr_write(12'h341, 32'h123, "mepc_align");

      csr_write(12'h300, 32'h8, "junk.setup");
      do_retire(32'hB00, 1, 4'd11, 32'h77, 0, 3'b000, 3'b000, 32'h300, 1, "csr_in_save");

      csr_write(12'h300, 32'h8, "wrap.setup");
      do_retire(32'hFFFF_FFFC, 0, 4'd0, 32'h0, 0, 3'b001, 3'b001, 32'h201, 0, "wrap");

      csr_write(12'h300, 32'h8, "rst.setup");
      pc = 32'hC00; exc_valid = 1; exc_code = 4'd3; exc_tval = 32'h1; mtvec = 32'h400; retire = 1;
      @(negedge clk);
      retire = 0; exc_valid = 0;
      @(negedge clk);
      check_eq("rst.vec_redir", {31'd0, redirect}, 32'd1);
      resetn = 1'b0;
      #1;
      model_reset();
      check_quiet("rst.abort");
      check_eq("rst.redirect_pc", redirect_pc, 32'd0);
      check_csrs("rst.abort");
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check_quiet("rst.after");
      check_csrs("rst.after");

      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 2) begin
            csr_write(csr_tab[$urandom_range(0, 4)], $urandom, "rnd.csr");
         end else if (r == 2) begin
            @(negedge clk);
            check_quiet("rnd.idle");
         end else begin
            do_retire($urandom, ($urandom_range(0, 3) == 0), exc_tab[$urandom_range(0, 5)],
                      $urandom, ($urandom_range(0, 4) == 0), 3'($urandom), 3'($urandom),
                      {$urandom_range(0, 32'h3FFF_FFFF), 1'b0, 1'($urandom_range(0, 1))},
                      1'($urandom_range(0, 1)), "rnd.retire");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trap_seq.md
# trap_seq

Machine-mode trap sequencer for the RV32 core. Sits between instruction retirement and fetch: samples exception reports from the exception detector and pending interrupt lines at each instruction boundary, arbitrates them, and sequences trap entry (mepc/mcause/mtval/mstatus update, redirect to mtvec) and `mret` return. Owns the trap CSRs; the processor reads them from the outputs and writes them through a simple CSR port.

## Interface
- RESET_PC_UNUSED: none; block has no parameters (widths fixed at RV32).
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- retire  in  1  instruction boundary strobe (one cycle per retired instruction)
- pc  in  32  PC of the retiring instruction
- exc_valid  in  1  retiring instruction raised a synchronous exception
- exc_code  in  4  exception cause (0 fetch misaligned, 2 illegal, 3 ebreak, 4 load misaligned, 6 store misaligned, 11 ecall)
- exc_tval  in  32  faulting address/instruction for mtval
- mret  in  1  retiring instruction is `mret`
- irq_pending  in  3  {MEI, MTI, MSI} level-sensitive pending lines
- mie  in  3  {MEIE, MTIE, MSIE} enables
- mtvec  in  32  trap vector (mode in [1:0]: 00 direct, 01 vectored)
- csr_we  in  1  CSR write strobe
- csr_addr  in  12  0x300 mstatus, 0x341 mepc, 0x342 mcause, 0x343 mtval
- csr_wdata  in  32  CSR write data
- stall  out  1  hold fetch/retire while sequencing
- redirect  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  target PC, valid when redirect=1
- mepc, mcause, mtval  out  32  trap CSRs
- mstatus_mie, mstatus_mpie  out  1  mstatus bits 3 and 7

## Operation
- States: IDLE, SAVE, VECTOR, RET.
- IDLE, retire=1: event selection, priority high→low: exc_valid; mret; interrupts MEI > MSI > MTI, each only if mstatus_mie=1 and mie bit=1 and irq_pending bit=1.
- Exception → latch cause=exc_code, epc=pc, tval=exc_tval; go SAVE.
- Interrupt → latch cause={1'b1,27'b0,code} (11/3/7), epc=pc+4, tval=0; go SAVE.
- mret (no exception) → mstatus_mie←mstatus_mpie, mstatus_mpie←1; go RET.
- No event → stay IDLE.
- SAVE: mepc←{epc[31:2],2'b00}, mcause←cause, mtval←tval, mstatus_mpie←mstatus_mie, mstatus_mie←0; go VECTOR.
- VECTOR: redirect=1; redirect_pc={mtvec[31:2],2'b00}, plus 4×code if mtvec[1:0]=01 and cause is interrupt; go IDLE.
- RET: redirect=1, redirect_pc=mepc; go IDLE.
- CSR writes accepted only in IDLE; ignored otherwise. mepc write forces [1:0]=00. mstatus write updates only bits 3 and 7. Trap/mret update wins over a CSR write on the same edge.
- pc+4 wraps modulo 2^32.

## Timing
- Reset: state IDLE; all outputs 0 (mepc, mcause, mtval, mstatus_mie, mstatus_mpie, stall, redirect, redirect_pc).
- stall = (state != IDLE), registered-state decode; retire must be 0 while stall=1 (ignored if not).
- Trap: retire sampled at edge N → SAVE in cycle N+1 (stall=1) → CSRs updated at edge N+1 → VECTOR in N+2 (redirect=1) → IDLE at N+3. Redirect latency 2 cycles.
- mret: sampled at edge N → mstatus updated at edge N, RET in N+1 (redirect=1) → IDLE. Latency 1 cycle.
- mret and pending enabled interrupt on same retire: mret taken; interrupt re-evaluated at next retire with restored MIE.
- irq_pending deasserting during SAVE/VECTOR does not cancel the trap.
- resetn low mid-sequence: immediate abort to IDLE, no redirect, outputs to reset values.

## Structure
- Package trap_pkg: state enum, exception/interrupt cause constants, CSR address constants, mtvec mode constants.
- Sub-module trap_prio: combinational arbiter (exc/mret/MEI/MSI/MTI → kind + cause code); FSM and CSR registers in trap_seq.

## Test plan
- Illegal instruction: retire, exc_valid, exc_code=2, pc=0x100, tval=0x0000FFFF, mtvec=0x200 → two cycles later redirect=1, redirect_pc=0x200; mepc=0x100, mcause=2, mtval=0xFFFF, mie=0, mpie=1.
- Vectored timer interrupt: mstatus_mie=1, mie=3'b010, irq_pending=3'b010, pc=0x400, mtvec=0x201 → redirect_pc=0x21C, mcause=0x80000007, mepc=0x404, mtval=0.
- Priority: exception code 4 plus MEI pending/enabled on same retire → mcause=4; MEI+MTI both pending → mcause=0x8000000B.
- mret: mepc=0x104, mpie=1, mie=0, retire+mret → next cycle redirect=1, redirect_pc=0x104; mie=1, mpie=1.
- Masking/CSR: mstatus_mie=0 with MEI pending → no trap; csr write 0x341 data 0x123 → mepc=0x120; csr write during SAVE ignored.
- Reset: assert resetn=0 in VECTOR cycle → redirect stays 0, all outputs 0, state IDLE.
